gabor_sym_conv_pipe: RTL and testbench

Pipelined, parametrised symmetric-kernel convolution block for the Gabor filter path. It accepts one signed K×K pixel window per beat. Mirrored pixels are pre-summed into (K+1)/2 clusters, selected per beat by an orientation mode (column-mirror 180° or row-mirror 90°). Each cluster sum is multiplied by a programmable fixed-point coefficient, and the rounded products are accumulated into one saturated result. It sits between the line-buffer window generator and the per-orientation response combiner, and adds valid/ready flow control and a coefficient register bank.

---
 rtl/gabor_pkg.sv | 35 +++
 rtl/gabor_sym_conv_pipe_mul.sv | 25 ++
 rtl/gabor_sym_conv_pipe.sv | 115 +++++++++++
 tb/tb_gabor_sym_conv_pipe.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gabor_pkg.sv
// rtl/gabor_pkg.sv - shared types and helpers for the symmetric Gabor convolution pipe
package gabor_pkg;

  typedef enum logic {
    MODE_COL180 = 1'b0,
    MODE_ROW90  = 1'b1
  } mode_e;

  // Mirrored rows/columns fold onto the nearer edge index; the centre line lands on NCL-1.
  function automatic int clusters_of(input mode_e mode, input int r, input int c, input int ksize);
    int d;
    d = (mode == MODE_ROW90) ? r : c;
    return (d < ksize - 1 - d) ? d : ksize - 1 - d;
  endfunction

  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int res_w,
                                                   output logic sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] res;
    hi  = (64'sd1 <<< (res_w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    sat = 1'b0;
    res = v;
    if (v > hi) begin
      res = hi;
      sat = 1'b1;
    end else if (v < lo) begin
      res = lo;
      sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/gabor_sym_conv_pipe_mul.sv
// rtl/gabor_sym_conv_pipe_mul.sv - signed fixed-point multiply with round-half-up or floor scaling
module gabor_fxp_mul_rnd #(
  parameter int A_W   = 13,
  parameter int B_W   = 17,
  parameter int FRAC  = 15,
  parameter int ROUND = 1
) (
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [A_W+B_W:0] p
);

  localparam int P_W = A_W + B_W + 1;
  localparam int HSH = (FRAC > 0) ? FRAC - 1 : 0;
  // One guard bit above the full product keeps the rounding add from overflowing.
  localparam logic signed [P_W-1:0] HALF = (ROUND != 0 && FRAC > 0) ? (P_W'(1) << HSH) : '0;

  logic signed [P_W-1:0] ae;
  logic signed [P_W-1:0] be;

  assign ae = P_W'(a);
  assign be = P_W'(b);
  assign p  = (ae * be + HALF) >>> FRAC;

endmodule

// File: rtl/gabor_sym_conv_pipe.sv
// rtl/gabor_sym_conv_pipe.sv - four-stage symmetric-kernel convolution with coefficient bank
module gabor_sym_conv_pipe
  import gabor_pkg::*;
#(
  parameter int  KSIZE    = 5,
  parameter int  PIX_W    = 9,
  parameter int  COEF_INT = 2,
  parameter int  COEF_DEC = 15,
  parameter int  ROUND    = 1,
  parameter int  RES_W    = 26,
  localparam int NCL      = (KSIZE + 1) / 2,
  localparam int IDX_W    = $clog2(NCL),
  localparam int CW       = COEF_INT + COEF_DEC,
  localparam int WIN_W    = KSIZE * KSIZE * PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIN_W-1:0] win_i,
  input  logic             mode_i,
  input  logic             coeff_wr,
  input  logic [IDX_W-1:0] coeff_idx,
  input  logic [CW-1:0]    coeff_data,
  output logic             coeff_busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] result_o,
  output logic             sat_o
);

  localparam int SUM_W = PIX_W + $clog2(2 * KSIZE);
  localparam int P_W   = SUM_W + CW + 1;
  localparam int ACC_W = P_W + $clog2(NCL) + 1;

  logic                    en;
  logic                    s1_v, s2_v, s3_v;
  logic [WIN_W-1:0]        s1_win;
  mode_e                   s1_mode;
  logic signed [SUM_W-1:0] sum_c  [NCL];
  logic signed [SUM_W-1:0] s2_sum [NCL];
  logic signed [CW-1:0]    coef   [NCL];
  logic signed [P_W-1:0]   prod_c [NCL];
  logic signed [P_W-1:0]   s3_prod[NCL];
  logic signed [ACC_W-1:0] acc_c;
  logic signed [63:0]      clamp_c;
  logic                    sat_c;

  assign en         = !out_valid || out_ready;
  assign in_ready   = en;
  assign coeff_busy = s1_v || s2_v || s3_v || out_valid;

  always_comb begin
    logic [IDX_W-1:0] k;
    k = '0;
    for (int j = 0; j < NCL; j++) sum_c[j] = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        k = IDX_W'(clusters_of(s1_mode, r, c, KSIZE));
        sum_c[k] = sum_c[k] + SUM_W'($signed(s1_win[(r*KSIZE+c)*PIX_W +: PIX_W]));
      end
    end
  end

  for (genvar j = 0; j < NCL; j++) begin : g_mul
    gabor_fxp_mul_rnd #(
      .A_W  (SUM_W),
      .B_W  (CW),
      .FRAC (COEF_DEC),
      .ROUND(ROUND)
    ) u_mul (
      .a(s2_sum[j]),
      .b(coef[j]),
      .p(prod_c[j])
    );
  end

  always_comb begin
    acc_c = '0;
    sat_c = 1'b0;
    for (int j = 0; j < NCL; j++) acc_c = acc_c + ACC_W'(s3_prod[j]);
    clamp_c = sat_clamp(64'(acc_c), RES_W, sat_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      s3_v      <= 1'b0;
      out_valid <= 1'b0;
      result_o  <= '0;
      sat_o     <= 1'b0;
      for (int j = 0; j < NCL; j++) coef[j] <= '0;
    end else begin
      // Writes only land on an empty pipe with no beat offered, so no beat sees a half-updated bank.
      if (coeff_wr && !coeff_busy && !in_valid && (int'(coeff_idx) < NCL))
        coef[coeff_idx] <= coeff_data;
      if (en) begin
        s1_v      <= in_valid;
        s1_win    <= win_i;
        s1_mode   <= mode_e'(mode_i);
        s2_v      <= s1_v;
        s2_sum    <= sum_c;
        s3_v      <= s2_v;
        s3_prod   <= prod_c;
        out_valid <= s3_v;
        if (s3_v) begin
          result_o <= clamp_c[RES_W-1:0];
          sat_o    <= sat_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_gabor_sym_conv_pipe.sv
// tb/tb_gabor_sym_conv_pipe.sv - self-checking bench for gabor_sym_conv_pipe
module tb_gabor_sym_conv_pipe;

  localparam int K     = 5;
  localparam int PW    = 9;
  localparam int CW    = 17;
  localparam int NCL   = 3;
  localparam int IW    = 2;
  localparam int WIN_W = K * K * PW;

  typedef struct packed {
    logic [WIN_W-1:0] win;
    logic             mode;
    logic [3*32-1:0]  cf;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst, in_valid, mode_i, coeff_wr, out_ready;
  logic [WIN_W-1:0] win_i;
  logic [IW-1:0]    coeff_idx;
  logic [CW-1:0]    coeff_data;

  logic        in_ready, coeff_busy, out_valid, sat_o;
  logic [25:0] result_o;
  logic        in_ready_tr, coeff_busy_tr, out_valid_tr, sat_tr;
  logic [25:0] result_tr;
  logic        in_ready_sat, coeff_busy_sat, out_valid_sat, sat_sat;
  logic [11:0] result_sat;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     m_coef[NCL];
  beat_t  q[$];
  longint got0[$], got_tr[$], got_sat[$];
  longint gsat0[$], gsat_sat[$];

  gabor_sym_conv_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .win_i(win_i),
    .mode_i(mode_i), .coeff_wr(coeff_wr), .coeff_idx(coeff_idx), .coeff_data(coeff_data),
    .coeff_busy(coeff_busy), .out_valid(out_valid), .out_ready(out_ready),
    .result_o(result_o), .sat_o(sat_o)
  );

  gabor_sym_conv_pipe #(.ROUND(0)) dut_tr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_tr), .win_i(win_i),
    .mode_i(mode_i), .coeff_wr(coeff_wr), .coeff_idx(coeff_idx), .coeff_data(coeff_data),
    .coeff_busy(coeff_busy_tr), .out_valid(out_valid_tr), .out_ready(out_ready),
    .result_o(result_tr), .sat_o(sat_tr)
  );

  gabor_sym_conv_pipe #(.RES_W(12)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_sat), .win_i(win_i),
    .mode_i(mode_i), .coeff_wr(coeff_wr), .coeff_idx(coeff_idx), .coeff_data(coeff_data),
    .coeff_busy(coeff_busy_sat), .out_valid(out_valid_sat), .out_ready(out_ready),
    .result_o(result_sat), .sat_o(sat_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Mirror distance from the centre line decides the cluster; each cluster is scaled on its own.
  function automatic longint model(input beat_t b, input int rnd, input int resw, output longint sat);
    longint sums[NCL];
    longint acc, prod, hi, lo;
    logic signed [PW-1:0] px;
    int d, co;
    for (int j = 0; j < NCL; j++) sums[j] = 0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        px = b.win[(r*K+c)*PW +: PW];
        d  = (b.mode ? r : c) - K / 2;
        if (d < 0) d = -d;
        sums[K/2 - d] += longint'(px);
      end
    end
    acc = 0;
    for (int j = 0; j < NCL; j++) begin
      co   = b.cf[j*32 +: 32];
      prod = sums[j] * longint'(co);
      if (rnd != 0) prod += 16384;
      acc += prod >>> 15;
    end
    hi  = (longint'(1) << (resw - 1)) - 1;
    lo  = -hi - 1;
    sat = 0;
    if (acc > hi) begin acc = hi; sat = 1; end
    else if (acc < lo) begin acc = lo; sat = 1; end
    return acc;
  endfunction

  always @(negedge clk) begin : compare
    beat_t  b;
    longint e, s;
    if (rst) begin
      q.delete();
    end else begin
      chk("busy_vs_inflight", longint'(coeff_busy), longint'(q.size() != 0));
      chk("in_ready_rule", longint'(in_ready), longint'(!out_valid || out_ready));
      chk("lockstep", longint'({out_valid_tr, out_valid_sat, coeff_busy_tr, coeff_busy_sat}),
          longint'({out_valid, out_valid, coeff_busy, coeff_busy}));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", longint'(out_valid), 0);
        end else begin
          b = q.pop_front();
          e = model(b, 1, 26, s);
          chk("res_main", longint'($signed(result_o)), e);
          chk("sat_main", longint'(sat_o), s);
          e = model(b, 0, 26, s);
          chk("res_trunc", longint'($signed(result_tr)), e);
          chk("sat_trunc", longint'(sat_tr), s);
          e = model(b, 1, 12, s);
          chk("res_sat12", longint'($signed(result_sat)), e);
          chk("sat_sat12", longint'(sat_sat), s);
          got0.push_back(longint'($signed(result_o)));
          got_tr.push_back(longint'($signed(result_tr)));
          got_sat.push_back(longint'($signed(result_sat)));
          gsat0.push_back(longint'(sat_o));
          gsat_sat.push_back(longint'(sat_sat));
        end
      end
      if (in_valid && in_ready)
        q.push_back('{win: win_i, mode: mode_i, cf: {m_coef[2], m_coef[1], m_coef[0]}});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_obs();
    got0.delete(); got_tr.delete(); got_sat.delete(); gsat0.delete(); gsat_sat.delete();
  endtask

  task automatic send_beat(input logic [WIN_W-1:0] w, input logic m);
    bit acc;
    int guard;
    in_valid = 1'b1;
    win_i    = w;
    mode_i   = m;
    acc      = 1'b0;
    guard    = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      guard++;
    end
    if (!acc) chk("send_timeout", longint'(acc), 1);
  endtask

  task automatic write_coef(input int idx, input int data, input bit take);
    coeff_wr   = 1'b1;
    coeff_idx  = IW'(idx);
    coeff_data = CW'(data);
    tick();
    coeff_wr = 1'b0;
    if (take && idx < NCL) m_coef[idx] = data;
  endtask

  function automatic logic [WIN_W-1:0] fill(input int v);
    logic [WIN_W-1:0] w;
    for (int i = 0; i < K * K; i++) w[i*PW +: PW] = PW'(v);
    return w;
  endfunction

  function automatic logic [WIN_W-1:0] one_pix(input int r, input int c, input int v);
    logic [WIN_W-1:0] w;
    w = '0;
    w[(r*K+c)*PW +: PW] = PW'(v);
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int first;
    int waited;
    rst = 1'b1; in_valid = 1'b0; win_i = '0; mode_i = 1'b0;
    coeff_wr = 1'b0; coeff_idx = '0; coeff_data = '0; out_ready = 1'b1;
    for (int i = 0; i < NCL; i++) m_coef[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_result", longint'(result_o), 0);
    chk("rst_sat", longint'(sat_o), 0);
    chk("rst_busy", longint'(coeff_busy), 0);
    chk("rst_in_ready", longint'(in_ready), 1);

    // all ones, unit coefficients: 10 + 10 + 5
    for (int j = 0; j < NCL; j++) write_coef(j, 32768, 1'b1);
    send_beat(fill(1), 1'b0);
    in_valid = 1'b0;
    chk("lat_accept_edge", longint'(out_valid), 0);
    first = 0;
    for (int k = 2; k <= 6; k++) begin
      tick();
      if (out_valid && first == 0) begin
        first = k;
        chk("t1_result", longint'($signed(result_o)), 25);
        chk("t1_sat", longint'(sat_o), 0);
      end
    end
    chk("t1_latency_edges", first, 4);
    idle(4);

    // six beats with a three-cycle output stall after the second result
    clear_obs();
    fork
      begin
        for (int i = 1; i <= 6; i++) send_beat(one_pix(2, 2, i * 10), 1'b0);
        in_valid = 1'b0;
      end
      begin
        waited = 0;
        while (!(out_valid && got0.size() == 1) && waited < 40) begin
          tick();
          waited++;
        end
        chk("stall_reached", longint'(out_valid && got0.size() == 1), 1);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", longint'(in_ready), 0);
          chk("stall_out_valid", longint'(out_valid), 1);
        end
        tick();
        out_ready = 1'b1;
      end
    join
    idle(10);
    chk("stall_count", got0.size(), 6);
    for (int i = 0; i < 6; i++) chk("stall_order", got0[i], longint'((i + 1) * 10));

    // writes dropped while a beat is offered, while in flight, and for an out-of-range index
    clear_obs();
    chk("t3_idle_busy", longint'(coeff_busy), 0);
    coeff_wr = 1'b1; coeff_idx = 2'd2; coeff_data = CW'(16384);
    send_beat(one_pix(2, 2, 4), 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_busy_inflight", longint'(coeff_busy), 1);
    tick();
    coeff_wr = 1'b0;
    idle(8);
    write_coef(3, 16384, 1'b0);
    write_coef(2, 16384, 1'b1);
    send_beat(one_pix(2, 2, 4), 1'b0);
    idle(8);
    chk("t3_count", got0.size(), 2);
    chk("t3_before_write", got0[0], 4);
    chk("t3_after_write", got0[1], 2);

    // single pixel (0,1)=8: column mirror hits cluster 1, row mirror hits cluster 0
    clear_obs();
    write_coef(0, 16384, 1'b1);
    write_coef(1, -32768, 1'b1);
    write_coef(2, 8192, 1'b1);
    send_beat(one_pix(0, 1, 8), 1'b0);
    idle(8);
    send_beat(one_pix(0, 1, 8), 1'b1);
    idle(8);
    for (int i = 0; i < 4; i++) send_beat(one_pix(0, 1, 8), 1'(i % 2));
    idle(8);
    chk("t4_count", got0.size(), 6);
    for (int i = 0; i < 6; i++) chk("t4_mode_seq", got0[i], (i % 2 == 0) ? -8 : 4);

    // centre +-3 times 0.5: round-half-up vs floor
    clear_obs();
    write_coef(2, 16384, 1'b1);
    send_beat(one_pix(2, 2, 3), 1'b0);
    send_beat(one_pix(2, 2, -3), 1'b1);
    idle(8);
    chk("t5_round_pos", got0[0], 2);
    chk("t5_round_neg", got0[1], -1);
    chk("t5_trunc_pos", got_tr[0], 1);
    chk("t5_trunc_neg", got_tr[1], -2);

    // saturation on the 12-bit instance
    clear_obs();
    for (int j = 0; j < NCL; j++) write_coef(j, 65535, 1'b1);
    send_beat(fill(255), 1'b0);
    send_beat(fill(-256), 1'b0);
    idle(8);
    chk("t6_sat12_pos", got_sat[0], 2047);
    chk("t6_sat12_pos_flag", gsat_sat[0], 1);
    chk("t6_sat12_neg", got_sat[1], -2048);
    chk("t6_sat12_neg_flag", gsat_sat[1], 1);
    chk("t6_wide_pos", got0[0], 12750);
    chk("t6_wide_flag", gsat0[0], 0);

    // reset mid-stream, with a beat offered in the reset cycle
    clear_obs();
    for (int i = 0; i < 3; i++) send_beat(fill(1), 1'b0);
    rst = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < NCL; i++) m_coef[i] = 0;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("t7_out_valid", longint'(out_valid), 0);
    chk("t7_result", longint'(result_o), 0);
    chk("t7_sat", longint'(sat_o), 0);
    chk("t7_busy", longint'(coeff_busy), 0);
    chk("t7_in_ready", longint'(in_ready), 1);
    idle(8);
    chk("t7_flushed", got0.size(), 0);
    send_beat(fill(1), 1'b0);
    idle(8);
    chk("t7_zero_coef_count", got0.size(), 1);
    chk("t7_zero_coef", got0[0], 0);

    chk("all_delivered", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
